// File: rtl/sparc_boot_loader.sv
// Boot loader for the SPARC MPU RAM port: streams bytes into RAM over the mov/MFC
// handshake, then releases the CPU and passes its memory signals straight through.
module sparc_boot_loader #(
    parameter int ADDR_W      = 9,
    parameter int BASE_ADDR   = 0,
    parameter int MFC_TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              Start,
    input  logic [7:0]        InData,
    input  logic              InValid,
    input  logic              InLast,
    output logic              InReady,
    output logic [ADDR_W-1:0] RamAddr,
    output logic [31:0]       RamData,
    output logic              RamMov,
    output logic              RamRW,
    output logic [1:0]        RamType,
    input  logic              RamMFC,
    input  logic [ADDR_W-1:0] CpuAddr,
    input  logic [31:0]       CpuData,
    input  logic              CpuMov,
    input  logic              CpuRW,
    input  logic [1:0]        CpuType,
    output logic              CpuMFC,
    output logic              CpuHold,
    output logic              Done,
    output logic              Err,
    output logic [ADDR_W:0]   ByteCount
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_RUN, S_ERR} state_t;

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;
    localparam logic [7:0]        TMO_LST = 8'(MFC_TIMEOUT - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [7:0]        byte_q;
    logic              last_q;
    logic [7:0]        timer_q;
    logic [ADDR_W:0]   cnt_q;
    logic              ready_q, mov_q, rw_q, done_q, err_q, hold_q;
    logic              run;

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q <= S_IDLE;
            ptr_q   <= BASE;
            byte_q  <= 8'h00;
            last_q  <= 1'b0;
            timer_q <= 8'h00;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            mov_q   <= 1'b0;
            rw_q    <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (Start) begin
                    state_q <= S_LOAD;
                    ptr_q   <= BASE;
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                end
                S_LOAD: if (InValid) begin
                    byte_q  <= InData;
                    last_q  <= InLast;
                    ready_q <= 1'b0;
                    mov_q   <= 1'b1;
                    rw_q    <= 1'b0;
                    timer_q <= 8'h00;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    // MFC takes priority over a timeout landing on the same edge
                    if (RamMFC) begin
                        mov_q <= 1'b0;
                        rw_q  <= 1'b1;
                        cnt_q <= cnt_q + (ADDR_W+1)'(1);
                        if (ptr_q != PTR_MAX)
                            ptr_q <= ptr_q + ADDR_W'(1);
                        if (last_q) begin
                            state_q <= S_RUN;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                        end else if (ptr_q == PTR_MAX) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= S_LOAD;
                            ready_q <= 1'b1;
                        end
                    end else if (timer_q == TMO_LST) begin
                        state_q <= S_ERR;
                        mov_q   <= 1'b0;
                        rw_q    <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign run       = (state_q == S_RUN);
    assign RamAddr   = run ? CpuAddr : ptr_q;
    assign RamData   = run ? CpuData : {24'h0, byte_q};
    assign RamMov    = run ? CpuMov  : mov_q;
    assign RamRW     = run ? CpuRW   : rw_q;
    assign RamType   = run ? CpuType : 2'b00;
    assign CpuMFC    = run & RamMFC;
    assign InReady   = ready_q;
    assign CpuHold   = hold_q;
    assign Done      = done_q;
    assign Err       = err_q;
    assign ByteCount = cnt_q;
endmodule

// File: tb/tb_sparc_boot_loader.sv
// Bench for sparc_boot_loader: behavioural RAM responder plus byte-image scoreboard.
module tb_sparc_boot_loader;
    logic        Clk, Clr;
    logic        Start, InValid, InLast, Start2, InValid2, InLast2;
    logic [7:0]  InData, InData2;
    logic        InReady, RamMov, RamRW, CpuMFC, CpuHold, Done, Err;
    logic        InReady2, RamMov2, RamRW2, CpuMFC2, CpuHold2, Done2, Err2;
    logic [8:0]  RamAddr, RamAddr2, CpuAddr;
    logic [31:0] RamData, RamData2, CpuData;
    logic [1:0]  RamType, RamType2, CpuType;
    logic [9:0]  ByteCount, ByteCount2;
    logic        CpuMov, CpuRW;
    logic        mfc, mfc2;

    int total = 0, bad = 0;
    // responder model state
    logic [7:0] mem [0:511];
    int  wlog[$], wlog2[$];
    bit  mfc_en = 1, rand_dly = 0;
    int  fixed_dly = 2, cur_dly = 2, wcnt = 0, wcnt2 = 0, mov_cyc = 0, bad_fmt = 0;

    sparc_boot_loader dut (
        .Clk(Clk), .Clr(Clr), .Start(Start), .InData(InData), .InValid(InValid),
        .InLast(InLast), .InReady(InReady), .RamAddr(RamAddr), .RamData(RamData),
        .RamMov(RamMov), .RamRW(RamRW), .RamType(RamType), .RamMFC(mfc),
        .CpuAddr(CpuAddr), .CpuData(CpuData), .CpuMov(CpuMov), .CpuRW(CpuRW),
        .CpuType(CpuType), .CpuMFC(CpuMFC), .CpuHold(CpuHold), .Done(Done),
        .Err(Err), .ByteCount(ByteCount));

    sparc_boot_loader #(.ADDR_W(9), .BASE_ADDR(510), .MFC_TIMEOUT(15)) dut2 (
        .Clk(Clk), .Clr(Clr), .Start(Start2), .InData(InData2), .InValid(InValid2),
        .InLast(InLast2), .InReady(InReady2), .RamAddr(RamAddr2), .RamData(RamData2),
        .RamMov(RamMov2), .RamRW(RamRW2), .RamType(RamType2), .RamMFC(mfc2),
        .CpuAddr(CpuAddr), .CpuData(CpuData), .CpuMov(CpuMov), .CpuRW(CpuRW),
        .CpuType(CpuType), .CpuMFC(CpuMFC2), .CpuHold(CpuHold2), .Done(Done2),
        .Err(Err2), .ByteCount(ByteCount2));

    initial begin
        Clk = 0;
        forever #5 Clk = ~Clk;
    end

    // RAM model for dut: completes a request cur_dly cycles after it is seen
    initial begin
        mfc = 0;
        forever begin
            @(negedge Clk);
            if (mfc) begin
                mfc = 0; wcnt = 0;
            end else if (RamMov && Clr) begin
                if (!Done && (RamRW !== 1'b0 || RamType !== 2'b00)) bad_fmt++;
                mov_cyc++;
                wcnt++;
                if (mfc_en && wcnt >= cur_dly) begin
                    mfc = 1;
                    if (!RamRW) begin
                        mem[RamAddr] = RamData[7:0];
                        wlog.push_back(int'(RamAddr));
                    end
                    cur_dly = rand_dly ? int'($urandom_range(1, 6)) : fixed_dly;
                end
            end else wcnt = 0;
        end
    end

    // RAM model for dut2: one-cycle latency
    initial begin
        mfc2 = 0;
        forever begin
            @(negedge Clk);
            if (mfc2) begin
                mfc2 = 0; wcnt2 = 0;
            end else if (RamMov2 && Clr) begin
                wcnt2++;
                if (wcnt2 >= 1) begin
                    mfc2 = 1;
                    wlog2.push_back(int'(RamAddr2));
                end
            end else wcnt2 = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        Start = 0; InValid = 0; InLast = 0; InData = 0;
        Start2 = 0; InValid2 = 0; InLast2 = 0; InData2 = 0;
        CpuAddr = 0; CpuData = 0; CpuMov = 0; CpuRW = 0; CpuType = 0;
        mfc_en = 1; rand_dly = 0; fixed_dly = 2; cur_dly = 2;
        wlog.delete(); wlog2.delete(); bad_fmt = 0; mov_cyc = 0;
        for (int i = 0; i < 512; i++) mem[i] = 'x;
        Clr = 0;
        #7;
        @(negedge Clk);
        Clr = 1;
    endtask

    task automatic pulse_start(input bit which);
        @(negedge Clk);
        if (which) Start2 = 1; else Start = 1;
        @(negedge Clk);
        Start = 0; Start2 = 0;
    endtask

    // present one byte, hold it until the loader takes it
    task automatic send(input bit which, input logic [7:0] b, input bit last, input int gap,
                        input bit start_in_gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            Start = start_in_gap && g == 0;
            @(negedge Clk);
            Start = 0;
        end
        if (which) begin InData2 = b; InLast2 = last; InValid2 = 1; end
        else       begin InData  = b; InLast  = last; InValid  = 1; end
        n = 0;
        while (!(which ? InReady2 : InReady) && n < 200) begin @(negedge Clk); n++; end
        chk("send_accept_timeout", 64'(n < 200), 64'd1);
        @(negedge Clk);
        InValid = 0; InLast = 0; InValid2 = 0; InLast2 = 0;
    endtask

    task automatic wait_flag(input bit which_done);
        int n = 0;
        while (!(which_done ? Done : Err) && n < 200) begin @(negedge Clk); n++; end
        chk(which_done ? "wait_done_timeout" : "wait_err_timeout", 64'(n < 200), 64'd1);
    endtask

    initial begin
        logic [7:0] img [0:2];
        logic [7:0] rimg [$];
        bit saw;
        int n;

        // reset state
        do_reset();
        Clr = 0; #1;
        chk("rst_InReady", 64'(InReady), 0);
        chk("rst_RamMov", 64'(RamMov), 0);
        chk("rst_RamRW", 64'(RamRW), 1);
        chk("rst_RamType", 64'(RamType), 0);
        chk("rst_RamAddr", 64'(RamAddr), 0);
        chk("rst_RamData", 64'(RamData), 0);
        chk("rst_CpuMFC", 64'(CpuMFC), 0);
        chk("rst_CpuHold", 64'(CpuHold), 1);
        chk("rst_Done_Err", {Done, Err}, 0);
        chk("rst_ByteCount", 64'(ByteCount), 0);
        @(negedge Clk); Clr = 1;

        // three-byte image, fixed 2-cycle MFC
        img[0] = 8'hA5; img[1] = 8'h3C; img[2] = 8'h0F;
        pulse_start(0);
        for (int i = 0; i < 3; i++) send(0, img[i], i == 2, 0, 0);
        wait_flag(1);
        #2;
        for (int i = 0; i < 3; i++) chk($sformatf("t1_mem%0d", i), 64'(mem[i]), 64'(img[i]));
        chk("t1_writes", 64'(wlog.size()), 3);
        chk("t1_ByteCount", 64'(ByteCount), 3);
        chk("t1_flags", {Done, CpuHold, Err}, 3'b100);
        chk("t1_write_fmt", 64'(bad_fmt), 0);

        // RUN: CPU owns the port
        @(negedge Clk);
        CpuAddr = 9'd1; CpuRW = 1; CpuMov = 1; CpuType = 2'b10; CpuData = 32'hDEADBEEF;
        #1;
        chk("t2_RamAddr", 64'(RamAddr), 1);
        chk("t2_RamMov_RW_Type", {RamMov, RamRW, RamType}, 4'b1110);
        chk("t2_RamData", 64'(RamData), 64'hDEADBEEF);
        saw = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk); #2;
            chk("t2_CpuMFC", 64'(CpuMFC), 64'(mfc));
            saw |= mfc;
        end
        chk("t2_saw_mfc", 64'(saw), 1);
        CpuMov = 0;

        // RAM never answers: timeout
        do_reset();
        mfc_en = 0;
        pulse_start(0);
        mov_cyc = 0;
        send(0, 8'h77, 0, 0, 0);
        wait_flag(0);
        #2;
        chk("t3_mov_cycles", 64'(mov_cyc), 15);
        chk("t3_flags", {Err, Done, CpuHold, RamMov, InReady}, 5'b10100);
        chk("t3_writes", 64'(wlog.size()), 0);

        // random image, random gaps and latency, stray Start mid-load
        do_reset();
        rand_dly = 1;
        rimg.delete();
        for (int i = 0; i < 12; i++) rimg.push_back(8'($urandom));
        pulse_start(0);
        for (int i = 0; i < 12; i++)
            send(0, rimg[i], i == 11, int'($urandom_range(0, 5)), i == 5 || i == 9);
        wait_flag(1);
        #2;
        chk("t5_writes", 64'(wlog.size()), 12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t5_mem%0d", i), 64'(mem[i]), 64'(rimg[i]));
            if (i < wlog.size()) chk($sformatf("t5_addr%0d", i), 64'(wlog[i]), 64'(i));
        end
        chk("t5_ByteCount", 64'(ByteCount), 12);
        chk("t5_write_fmt", 64'(bad_fmt), 0);

        // reset asserted while RamMov is high, then reload
        do_reset();
        mfc_en = 0;
        pulse_start(0);
        send(0, 8'h99, 0, 0, 0);
        @(negedge Clk); #3;
        chk("t6_mov_before", 64'(RamMov), 1);
        Clr = 0; #1;
        chk("t6_async_outs", {RamMov, InReady, RamRW, CpuHold, Done, Err}, 6'b001100);
        chk("t6_async_cnt_addr", {ByteCount, RamAddr}, 0);
        @(negedge Clk); Clr = 1;
        mfc_en = 1;
        wlog.delete();
        pulse_start(0);
        send(0, 8'h11, 0, 2, 0);
        send(0, 8'h22, 1, 1, 0);
        wait_flag(1);
        #2;
        chk("t6_first_addr", 64'(wlog.size() > 0 ? wlog[0] : -1), 0);
        chk("t6_mem", {mem[0], mem[1]}, 16'h1122);
        chk("t6_ByteCount", 64'(ByteCount), 2);

        // top-of-RAM overflow on dut2 (BASE_ADDR=510)
        pulse_start(1);
        send(1, 8'hA1, 0, 0, 0);
        send(1, 8'hA2, 0, 0, 0);
        InData2 = 8'hA3; InValid2 = 1;
        n = 0;
        while (!Err2 && n < 50) begin @(negedge Clk); n++; end
        repeat (3) @(negedge Clk);
        #2;
        chk("t4_err", {Err2, Done2, CpuHold2, RamMov2, InReady2}, 5'b10100);
        chk("t4_writes", 64'(wlog2.size()), 2);
        if (wlog2.size() >= 2) chk("t4_addrs", {32'(wlog2[0]), 32'(wlog2[1])}, {32'd510, 32'd511});
        chk("t4_ptr_nowrap", 64'(RamAddr2), 511);
        chk("t4_ByteCount", 64'(ByteCount2), 2);
        InValid2 = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
